// File: rtl/reg_file.sv
// Multi-entry register file with one write port, two registered read ports and a per-entry busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-edge write data (and reserve state) to the read ports.
module reg_file #(
  parameter  int WIDTH    = 64,
  parameter  int DEPTH    = 32,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             rbusy_a,
  output logic             rvalid_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rbusy_b,
  output logic             rvalid_b
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;

  logic             re_p0      [2];
  logic [AW-1:0]    raddr_p0   [2];
  logic [WIDTH-1:0] rd_data_p0 [2];
  logic             rd_busy_p0 [2];

  logic [WIDTH-1:0] rdata_p1   [2];
  logic             rbusy_p1   [2];
  logic             vld_p1     [2];

  // Entry 0 (when hardwired) and addresses past DEPTH are neither stored nor read.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_C) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign re_p0[0]    = re_a;
  assign re_p0[1]    = re_b;
  assign raddr_p0[0] = raddr_a;
  assign raddr_p0[1] = raddr_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && addr_ok(waddr)) begin
      mem[waddr] <= wdata;
    end
  end

  // Reserve is applied after the write clear so a same-edge new producer wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (we && addr_ok(waddr))     busy[waddr]    <= 1'b0;
      if (rsv && addr_ok(rsv_addr)) busy[rsv_addr] <= 1'b1;
    end
  end

  // Stage p0: operand lookup
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_p0[p] = '0;
      rd_busy_p0[p] = 1'b0;
      if (addr_ok(raddr_p0[p])) begin
`ifdef REG_FILE_BYPASS_EN
        if (we && (waddr == raddr_p0[p])) begin
          rd_data_p0[p] = wdata;
          rd_busy_p0[p] = rsv && (rsv_addr == raddr_p0[p]);
        end else begin
          rd_data_p0[p] = mem[raddr_p0[p]];
          rd_busy_p0[p] = busy[raddr_p0[p]];
        end
`else
        rd_data_p0[p] = mem[raddr_p0[p]];
        rd_busy_p0[p] = busy[raddr_p0[p]];
`endif
      end
    end
  end

  // Stage p1: registered read results; data/busy hold when no read is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        rdata_p1[p] <= '0;
        rbusy_p1[p] <= 1'b0;
        vld_p1[p]   <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        vld_p1[p] <= re_p0[p];
        if (re_p0[p]) begin
          rdata_p1[p] <= rd_data_p0[p];
          rbusy_p1[p] <= rd_busy_p0[p];
        end
      end
    end
  end

  assign rdata_a  = rdata_p1[0];
  assign rbusy_a  = rbusy_p1[0];
  assign rvalid_a = vld_p1[0];
  assign rdata_b  = rdata_p1[1];
  assign rbusy_b  = rbusy_p1[1];
  assign rvalid_b = vld_p1[1];

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file: directed vector table, mid-run reset sequence, randomized run against a reference model.
module tb_reg_file;
  localparam int W  = 64;
  localparam int D  = 20;
  localparam int AW = 5;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [63:0] D3 = 64'h0123456789ABCDEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          we, rsv, re_a, re_b;
  logic [AW-1:0] waddr, rsv_addr, raddr_a, raddr_b;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata_a, rdata_b;
  logic          rbusy_a, rbusy_b, rvalid_a, rvalid_b;

  always #5 clk = ~clk;

  reg_file #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .rsv(rsv), .rsv_addr(rsv_addr),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rbusy_a(rbusy_a), .rvalid_a(rvalid_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rbusy_b(rbusy_b), .rvalid_b(rvalid_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic we; logic [AW-1:0] wa; logic [63:0] wd;
    logic rs; logic [AW-1:0] rsa;
    logic rea; logic [AW-1:0] ra; logic reb; logic [AW-1:0] rb;
    logic va; logic [63:0] da; logic ba;
    logic vb; logic [63:0] db; logic bb;
  } vec_t;

  function automatic vec_t mk(input logic w, input int wa, input logic [63:0] wd,
                              input logic rs, input int rsa,
                              input logic ea, input int ra, input logic eb, input int rb,
                              input logic va, input logic [63:0] da, input logic ba,
                              input logic vb, input logic [63:0] db, input logic bb);
    vec_t v;
    v.we = w;   v.wa = AW'(wa);  v.wd = wd;
    v.rs = rs;  v.rsa = AW'(rsa);
    v.rea = ea; v.ra = AW'(ra);  v.reb = eb; v.rb = AW'(rb);
    v.va = va;  v.da = da; v.ba = ba;
    v.vb = vb;  v.db = db; v.bb = bb;
    return v;
  endfunction

  vec_t tbl[23];

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0; rsv = 1'b0; rsv_addr = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;
  endtask

  // Reference model: entries as a plain array, results computed from the pre-edge state.
  logic [63:0] m_mem [32];
  bit          m_busy[32];
  logic [63:0] e_da, e_db;
  bit          e_ba, e_bb, e_va, e_vb;

  function automatic bit m_ok(input int a);
    return (a < D) && (a != 0);
  endfunction

  task automatic m_read(input int a, output logic [63:0] d, output bit b);
    d = '0; b = 1'b0;
    if (m_ok(a)) begin
      if (BYP && we && int'(waddr) == a) begin
        d = wdata;
        b = rsv && int'(rsv_addr) == a;
      end else begin
        d = m_mem[a];
        b = m_busy[a];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    e_da = '0; e_db = '0; e_ba = 1'b0; e_bb = 1'b0; e_va = 1'b0; e_vb = 1'b0;
  endtask

  task automatic model_tick(input string tag);
    if (re_a) m_read(int'(raddr_a), e_da, e_ba);
    if (re_b) m_read(int'(raddr_b), e_db, e_bb);
    e_va = re_a; e_vb = re_b;
    if (we && m_ok(int'(waddr))) begin
      m_mem[waddr] = wdata;
      m_busy[waddr] = 1'b0;
    end
    if (rsv && m_ok(int'(rsv_addr))) m_busy[rsv_addr] = 1'b1;
    @(posedge clk); #1;
    chk({tag, " rvalid_a"}, 64'(rvalid_a), 64'(e_va));
    chk({tag, " rdata_a"},  rdata_a,       e_da);
    chk({tag, " rbusy_a"},  64'(rbusy_a),  64'(e_ba));
    chk({tag, " rvalid_b"}, 64'(rvalid_b), 64'(e_vb));
    chk({tag, " rdata_b"},  rdata_b,       e_db);
    chk({tag, " rbusy_b"},  64'(rbusy_b),  64'(e_bb));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rdata_a",  rdata_a,        64'h0);
    chk("reset rvalid_a", 64'(rvalid_a),  64'h0);
    chk("reset rbusy_a",  64'(rbusy_a),   64'h0);
    chk("reset rdata_b",  rdata_b,        64'h0);
    chk("reset rvalid_b", 64'(rvalid_b),  64'h0);
    chk("reset rbusy_b",  64'(rbusy_b),   64'h0);
    rst = 1'b0;

    //          we   wa  wdata     rs   rsa ea   ra  eb   rb   va   da                ba   vb   db                bb
    tbl[0]  = mk(1'b1, 3, D3,     1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 64'h0,           1'b0, 1'b0, 64'h0,           1'b0);
    tbl[1]  = mk(1'b0, 0, 64'h0,  1'b0, 0, 1'b1, 3, 1'b0, 0, 1'b1, D3,              1'b0, 1'b0, 64'h0,           1'b0);
    tbl[2]  = mk(1'b0, 0, 64'h0,  1'b1, 7, 1'b0, 0, 1'b0, 0, 1'b0, D3,              1'b0, 1'b0, 64'h0,           1'b0);
    tbl[3]  = mk(1'b0, 0, 64'h0,  1'b0, 0, 1'b1, 7, 1'b0, 0, 1'b1, 64'h0,           1'b1, 1'b0, 64'h0,           1'b0);
    tbl[4]  = mk(1'b1, 7, 64'h55, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 64'h0,           1'b1, 1'b0, 64'h0,           1'b0);
    tbl[5]  = mk(1'b0, 0, 64'h0,  1'b0, 0, 1'b1, 7, 1'b0, 0, 1'b1, 64'h55,          1'b0, 1'b0, 64'h0,           1'b0);
    tbl[6]  = mk(1'b1, 7, 64'h66, 1'b1, 7, 1'b0, 0, 1'b0, 0, 1'b0, 64'h55,          1'b0, 1'b0, 64'h0,           1'b0);
    tbl[7]  = mk(1'b0, 0, 64'h0,  1'b0, 0, 1'b1, 7, 1'b0, 0, 1'b1, 64'h66,          1'b1, 1'b0, 64'h0,           1'b0);
    tbl[8]  = mk(1'b1, 9, 64'h11, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 64'h66,          1'b1, 1'b0, 64'h0,           1'b0);
    tbl[9]  = mk(1'b1, 9, 64'h22, 1'b0, 0, 1'b1, 9, 1'b0, 0, 1'b1, BYP ? 64'h22 : 64'h11, 1'b0, 1'b0, 64'h0,     1'b0);
    tbl[10] = mk(1'b0, 0, 64'h0,  1'b0, 0, 1'b1, 9, 1'b0, 0, 1'b1, 64'h22,          1'b0, 1'b0, 64'h0,           1'b0);
    tbl[11] = mk(1'b1, 0, 64'hFF, 1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0, 64'h22,          1'b0, 1'b1, 64'h0,           1'b0);
    tbl[12] = mk(1'b0, 0, 64'h0,  1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0, 64'h22,          1'b0, 1'b1, 64'h0,           1'b0);
    tbl[13] = mk(1'b1, 25, 64'hBEEF, 1'b1, 25, 1'b0, 0, 1'b0, 0, 1'b0, 64'h22,      1'b0, 1'b0, 64'h0,           1'b0);
    tbl[14] = mk(1'b0, 0, 64'h0,  1'b0, 0, 1'b1, 25, 1'b1, 19, 1'b1, 64'h0,         1'b0, 1'b1, 64'h0,           1'b0);
    tbl[15] = mk(1'b1, 2, 64'hAA, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 64'h0,           1'b0, 1'b0, 64'h0,           1'b0);
    tbl[16] = mk(1'b0, 0, 64'h0,  1'b0, 0, 1'b1, 2, 1'b1, 2, 1'b1, 64'hAA,          1'b0, 1'b1, 64'hAA,          1'b0);
    tbl[17] = mk(1'b0, 0, 64'h0,  1'b0, 0, 1'b1, 2, 1'b1, 3, 1'b1, 64'hAA,          1'b0, 1'b1, D3,              1'b0);
    tbl[18] = mk(1'b0, 0, 64'h0,  1'b0, 0, 1'b1, 7, 1'b1, 2, 1'b1, 64'h66,          1'b1, 1'b1, 64'hAA,          1'b0);
    tbl[19] = mk(1'b0, 0, 64'h0,  1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 64'h66,          1'b1, 1'b0, 64'hAA,          1'b0);
    tbl[20] = mk(1'b0, 0, 64'h0,  1'b1, 4, 1'b1, 4, 1'b0, 0, 1'b1, 64'h0,           1'b0, 1'b0, 64'hAA,          1'b0);
    tbl[21] = mk(1'b0, 0, 64'h0,  1'b0, 0, 1'b1, 4, 1'b0, 0, 1'b1, 64'h0,           1'b1, 1'b0, 64'hAA,          1'b0);
    tbl[22] = mk(1'b1, 4, 64'h77, 1'b1, 4, 1'b0, 0, 1'b1, 4, 1'b0, 64'h0,           1'b1, 1'b1, BYP ? 64'h77 : 64'h0, 1'b1);

    for (int i = 0; i < 23; i++) begin
      we = tbl[i].we; waddr = tbl[i].wa; wdata = tbl[i].wd;
      rsv = tbl[i].rs; rsv_addr = tbl[i].rsa;
      re_a = tbl[i].rea; raddr_a = tbl[i].ra; re_b = tbl[i].reb; raddr_b = tbl[i].rb;
      @(posedge clk); #1;
      chk($sformatf("vec%0d rvalid_a", i), 64'(rvalid_a), 64'(tbl[i].va));
      chk($sformatf("vec%0d rdata_a", i),  rdata_a,       tbl[i].da);
      chk($sformatf("vec%0d rbusy_a", i),  64'(rbusy_a),  64'(tbl[i].ba));
      chk($sformatf("vec%0d rvalid_b", i), 64'(rvalid_b), 64'(tbl[i].vb));
      chk($sformatf("vec%0d rdata_b", i),  rdata_b,       tbl[i].db);
      chk($sformatf("vec%0d rbusy_b", i),  64'(rbusy_b),  64'(tbl[i].bb));
    end

    // Asynchronous reset in the middle of a read stream.
    idle_inputs();
    we = 1'b1; waddr = 5'd5; wdata = 64'hDEAD;
    @(posedge clk); #1;
    idle_inputs();
    re_a = 1'b1; raddr_a = 5'd5;
    @(posedge clk); #1;
    chk("pre-reset rdata_a",  rdata_a,       64'hDEAD);
    chk("pre-reset rvalid_a", 64'(rvalid_a), 64'h1);
    #3 rst = 1'b1;
    #1;
    chk("async reset rdata_a",  rdata_a,       64'h0);
    chk("async reset rvalid_a", 64'(rvalid_a), 64'h0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset r5 rdata_a",  rdata_a,       64'h0);
    chk("post-reset r5 rvalid_a", 64'(rvalid_a), 64'h1);
    raddr_a = 5'd3;
    @(posedge clk); #1;
    chk("post-reset r3 rdata_a",  rdata_a,       64'h0);
    idle_inputs();

    // Randomized traffic against the model; DUT state is all zero after the reset above.
    model_clear();
    for (int n = 0; n < 400; n++) begin
      we       = 1'($urandom_range(0, 1));
      waddr    = AW'($urandom_range(0, 23));
      wdata    = {$urandom, $urandom};
      rsv      = ($urandom_range(0, 3) == 0);
      rsv_addr = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, 23));
      re_a     = ($urandom_range(0, 3) != 0);
      raddr_a  = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 23));
      re_b     = ($urandom_range(0, 3) != 0);
      raddr_b  = ($urandom_range(0, 4) == 0) ? raddr_a : AW'($urandom_range(0, 23));
      model_tick($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
